// File: rtl/pulse_train_if.sv
// Control/status bundle for pulse_train_gen.
// master: the block driving start/stop and the sequence fields.
// slave:  the pulse generator itself.
interface pulse_train_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             stop;
    logic             mode;
    logic [CNT_W-1:0] width;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] count;
    logic             signal;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pulse_cnt;

    modport master (
        output start, stop, mode, width, period, count,
        input  signal, busy, done, pulse_cnt
    );

    modport slave (
        input  start, stop, mode, width, period, count,
        output signal, busy, done, pulse_cnt
    );
endinterface

// File: rtl/pulse_train_gen.sv
// Clock-counted pulse generator: one-shot or periodic (finite or
// free-running) pulse trains with start/stop control and busy/done status.
// The bus interface must be instantiated with the same CNT_W as this module.
module pulse_train_gen #(
    parameter int   CNT_W  = 8,
    parameter logic ACTIVE = 1'b1
) (
    input  logic          clock,
    input  logic          reset,
    pulse_train_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    // Phase counter is one bit wider than the fields: the clamped period
    // width+1 reaches 2^CNT_W when width is all ones.
    localparam logic [CNT_W:0]   PH_ONE  = {{CNT_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [CNT_W:0]   per_q, per_d;      // effective period P
    logic [CNT_W-1:0] count_q, count_d;
    logic             mode_q, mode_d;
    logic [CNT_W:0]   phase_q, phase_d;  // 1-based cycle position inside the period
    logic             signal_q, signal_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W:0]   eff_period;

    // Every period keeps at least one low cycle: short periods clamp to width+1.
    always_comb begin
        if (bus.period > bus.width)
            eff_period = {1'b0, bus.period};
        else
            eff_period = {1'b0, bus.width} + PH_ONE;
    end

    // Next-state and next-output logic; outputs are registered below.
    always_comb begin
        state_d  = state_q;
        width_d  = width_q;
        per_d    = per_q;
        count_d  = count_q;
        mode_d   = mode_q;
        phase_d  = phase_q;
        signal_d = signal_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pcnt_d   = pcnt_q;

        case (state_q)
            IDLE: begin
                // stop outranks start; a zero-width request is meaningless.
                if (bus.start && !bus.stop && (bus.width != '0)) begin
                    width_d  = bus.width;
                    per_d    = eff_period;
                    count_d  = bus.count;
                    mode_d   = bus.mode;
                    phase_d  = PH_ONE;
                    signal_d = ACTIVE;
                    busy_d   = 1'b1;
                    pcnt_d   = CNT_ONE;
                    state_d  = HIGH;
                end
            end

            HIGH: begin
                if (bus.stop) begin
                    state_d  = IDLE;
                    signal_d = ~ACTIVE;
                    busy_d   = 1'b0;
                end else if (phase_q == {1'b0, width_q}) begin
                    signal_d = ~ACTIVE;
                    if (!mode_q) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = LOW;
                        phase_d = phase_q + PH_ONE;
                    end
                end else begin
                    phase_d = phase_q + PH_ONE;
                end
            end

            LOW: begin
                if (bus.stop) begin
                    state_d  = IDLE;
                    signal_d = ~ACTIVE;
                    busy_d   = 1'b0;
                end else if (phase_q == per_q) begin
                    if ((count_q != '0) && (pcnt_q == count_q)) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = HIGH;
                        signal_d = ACTIVE;
                        pcnt_d   = pcnt_q + CNT_ONE;  // wraps when free-running
                        phase_d  = PH_ONE;
                    end
                end else begin
                    phase_d = phase_q + PH_ONE;
                end
            end

            default: begin
                state_d  = IDLE;
                signal_d = ~ACTIVE;
                busy_d   = 1'b0;
            end
        endcase
    end

    // State, latched fields, counters and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            width_q  <= '0;
            per_q    <= '0;
            count_q  <= '0;
            mode_q   <= 1'b0;
            phase_q  <= '0;
            signal_q <= ~ACTIVE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            width_q  <= width_d;
            per_q    <= per_d;
            count_q  <= count_d;
            mode_q   <= mode_d;
            phase_q  <= phase_d;
            signal_q <= signal_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pcnt_q   <= pcnt_d;
        end
    end

    assign bus.signal    = signal_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pulse_cnt = pcnt_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed bench for pulse_train_gen. Two instances (ACTIVE=1 and ACTIVE=0)
// share the stimulus; the driver queues the expected per-cycle outputs and a
// monitor pops one entry per falling edge and compares both instances.
module tb_pulse_train_gen;

    typedef struct packed {
        logic       sig;
        logic       busy;
        logic       done;
        logic [7:0] pc;
    } exp_t;

    logic       clock;
    logic       reset;
    logic       start, stop, mode;
    logic [7:0] width, period, count;

    exp_t sb[$];
    exp_t mon_e;
    int   tests;
    int   fails;
    int   cyc;

    pulse_train_if #(.CNT_W(8)) bus0 ();
    pulse_train_if #(.CNT_W(8)) bus1 ();

    assign bus0.start  = start;  assign bus1.start  = start;
    assign bus0.stop   = stop;   assign bus1.stop   = stop;
    assign bus0.mode   = mode;   assign bus1.mode   = mode;
    assign bus0.width  = width;  assign bus1.width  = width;
    assign bus0.period = period; assign bus1.period = period;
    assign bus0.count  = count;  assign bus1.count  = count;

    pulse_train_gen #(.CNT_W(8), .ACTIVE(1'b1)) dut_hi (
        .clock (clock),
        .reset (reset),
        .bus   (bus0)
    );

    pulse_train_gen #(.CNT_W(8), .ACTIVE(1'b0)) dut_lo (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Monitor: one queued expectation per falling edge.
    always @(negedge clock) begin
        cyc <= cyc + 1;
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            tests++;
            if ({bus0.signal, bus0.busy, bus0.done, bus0.pulse_cnt} !== mon_e ||
                {bus1.signal, bus1.busy, bus1.done, bus1.pulse_cnt} !==
                {~mon_e.sig, mon_e.busy, mon_e.done, mon_e.pc}) begin
                fails++;
                $display("FAIL cycle %0d: got sig=%b/%b busy=%b/%b done=%b/%b cnt=%0d/%0d, need sig=%b/%b busy=%b done=%b cnt=%0d",
                         cyc, bus0.signal, bus1.signal, bus0.busy, bus1.busy,
                         bus0.done, bus1.done, bus0.pulse_cnt, bus1.pulse_cnt,
                         mon_e.sig, ~mon_e.sig, mon_e.busy, mon_e.done, mon_e.pc);
            end
        end
    end

    // Queue the outputs expected after the next rising edge, then advance.
    task automatic step(input logic s, input logic b, input logic d, input logic [7:0] pc);
        exp_t e;
        e.sig  = s;
        e.busy = b;
        e.done = d;
        e.pc   = pc;
        sb.push_back(e);
        @(negedge clock);
        #1;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic expect_n(input int n, input logic s, input logic b, input logic d, input logic [7:0] pc);
        repeat (n) step(s, b, d, pc);
    endtask

    // Immediate check of the reset state on both instances.
    task automatic check_reset(input string name);
        tests++;
        if ({bus0.signal, bus0.busy, bus0.done, bus0.pulse_cnt} !== {1'b0, 1'b0, 1'b0, 8'd0} ||
            {bus1.signal, bus1.busy, bus1.done, bus1.pulse_cnt} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
            fails++;
            $display("FAIL %s: got sig=%b/%b busy=%b/%b done=%b/%b cnt=%0d/%0d, need sig=0/1 busy=0 done=0 cnt=0",
                     name, bus0.signal, bus1.signal, bus0.busy, bus1.busy,
                     bus0.done, bus1.done, bus0.pulse_cnt, bus1.pulse_cnt);
        end
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        cyc    = 0;
        reset  = 1'b1;
        start  = 1'b0;
        stop   = 1'b0;
        mode   = 1'b0;
        width  = 8'd0;
        period = 8'd0;
        count  = 8'd0;
        repeat (2) @(negedge clock);
        #1;
        reset = 1'b0;
        check_reset("reset_state");
        step(0, 0, 0, 0);

        // One-shot width 3; a start on the done edge is ignored, the next accepted.
        mode = 1'b0; width = 8'd3; start = 1'b1;
        expect_n(3, 1, 1, 0, 1);
        start = 1'b1;
        step(0, 0, 1, 1);
        start = 1'b1;
        expect_n(3, 1, 1, 0, 1);
        step(0, 0, 1, 1);
        step(0, 0, 0, 1);

        // Zero-width start does nothing.
        mode = 1'b1; width = 8'd0; period = 8'd4; start = 1'b1;
        expect_n(2, 0, 0, 0, 1);

        // Periodic 2/5 x3; inputs changed and start pulsed while busy.
        mode = 1'b1; width = 8'd2; period = 8'd5; count = 8'd3; start = 1'b1;
        step(1, 1, 0, 1);
        width = 8'd7; period = 8'd9; count = 8'd1; mode = 1'b0;
        step(1, 1, 0, 1);
        expect_n(3, 0, 1, 0, 1);
        start = 1'b1;
        expect_n(2, 1, 1, 0, 2);
        expect_n(3, 0, 1, 0, 2);
        expect_n(2, 1, 1, 0, 3);
        expect_n(3, 0, 1, 0, 3);
        step(0, 0, 1, 3);
        step(0, 0, 0, 3);

        // Clamped period: width 4, period 3 -> P = 5, two pulses.
        mode = 1'b1; width = 8'd4; period = 8'd3; count = 8'd2; start = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            expect_n(4, 1, 1, 0, 8'(i));
            expect_n(1, 0, 1, 0, 8'(i));
        end
        step(0, 0, 1, 2);
        step(0, 0, 0, 2);

        // Free-running 1/2 aborted at E0+7; start+stop together ignored.
        mode = 1'b1; width = 8'd1; period = 8'd2; count = 8'd0; start = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step(1, 1, 0, 8'(i));
            step(0, 1, 0, 8'(i));
        end
        step(1, 1, 0, 4);
        stop = 1'b1;
        step(0, 0, 0, 4);
        start = 1'b1; stop = 1'b1;
        step(0, 0, 0, 4);
        step(0, 0, 0, 4);

        // Free-running past 255 pulses: pulse_cnt wraps to 0.
        start = 1'b1;
        for (int i = 1; i <= 257; i++) begin
            step(1, 1, 0, 8'(i));
            step(0, 1, 0, 8'(i));
        end
        stop = 1'b1;
        step(0, 0, 0, 8'd1);

        // Asynchronous reset in the middle of a periodic run.
        mode = 1'b1; width = 8'd2; period = 8'd5; count = 8'd0; start = 1'b1;
        expect_n(2, 1, 1, 0, 1);
        step(0, 1, 0, 1);
        #2;
        reset = 1'b1;
        #1;
        check_reset("async_reset");
        @(negedge clock);
        #1;
        reset = 1'b0;
        step(0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
